// File: rtl/core_status_pkg.sv
// Constants and enumerations shared by the end-of-test status monitor.
package core_status_pkg;
   import tb_config_pkg::*;

   localparam logic [31:0] UNIMP_INSTR = 32'hC000_1073;
   localparam logic [4:0]  GP_IDX      = 5'd3;

   typedef enum logic [1:0] {
      RUNNING = 2'b00,
      PASS    = 2'b01,
      FAIL    = 2'b10,
      TOUT    = 2'b11
   } status_e;

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      DRAIN   = 2'b01,
      DONE    = 2'b10,
      TIMEOUT = 2'b11
   } mon_state_e;
endpackage

// File: rtl/tb_config_pkg.sv
// Shared configuration constants for the core top level and its test harness.
package tb_config_pkg;
   localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/watchdog_counter.sv
// Saturating 32-bit cycle counter with a terminal-count flag at TIMEOUT_CYCLES-1.
// A TIMEOUT_CYCLES of 0 keeps the flag permanently low.
module watchdog_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [31:0] count,
   output logic        tc
);
   localparam logic [31:0] TC_VAL = 32'(TIMEOUT_CYCLES) - 32'd1;
   localparam bit          WD_ON  = (TIMEOUT_CYCLES != 0);

   logic [31:0] count_d;
   logic [31:0] count_q;

   always_comb begin
      count_d = count_q;
      if (en && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc    = WD_ON && (count_q == TC_VAL);
endmodule

// File: rtl/core_status_monitor.sv
// End-of-test monitor: catches unimp in decode, drains the pipeline, shadows gp
// and publishes a frozen pass/fail/timeout result to the test interface.
module core_status_monitor
   import core_status_pkg::*;
#(
   parameter int          DATA_WIDTH     = tb_config_pkg::DATA_WIDTH,
   parameter int unsigned DRAIN_CYCLES   = 3,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [31:0]           id_instr,
   input  logic                  wb_we,
   input  logic [4:0]            wb_rd,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  core_halt,
   output logic                  io_coreDone,
   output logic [DATA_WIDTH-1:0] io_gpRegVal,
   output logic [DATA_WIDTH-1:0] io_check_res,
   output logic [31:0]           io_cycles
);
   localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYCLES) - 32'd1;

   mon_state_e            state_q, state_d;
   logic [31:0]           drain_cnt_q, drain_cnt_d;
   logic [DATA_WIDTH-1:0] gp_q, gp_d;
   logic [DATA_WIDTH-1:0] check_res_q, check_res_d;
   logic                  halt_q, halt_d;
   logic                  done_q, done_d;
   logic                  detect, active, gp_wr, wd_tc;
   status_e               final_st;

   // Status in the top two bits; a fail carries gp>>1, the riscv-tests test number.
   function automatic logic [DATA_WIDTH-1:0] encode_result(input status_e st,
                                                          input logic [DATA_WIDTH-1:0] gp);
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      r[DATA_WIDTH-1 -: 2] = st;
      if (st == FAIL) begin
         r[DATA_WIDTH-3:0] = gp[DATA_WIDTH-2:1];
      end else begin
         r[DATA_WIDTH-3:0] = '0;
      end
      return r;
   endfunction

   assign detect = id_valid && (id_instr == UNIMP_INSTR);
   assign active = (state_q == RUN) || (state_q == DRAIN);
   assign gp_wr  = active && wb_we && (wb_rd == GP_IDX);

   watchdog_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (active),
      .count(io_cycles),
      .tc   (wd_tc)
   );

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      check_res_d = check_res_q;
      gp_d        = gp_wr ? wb_data : gp_q;
      final_st    = (gp_d == DATA_WIDTH'(1)) ? PASS : FAIL;
      case (state_q)
         RUN: begin
            if (detect) begin
               state_d     = DRAIN;
               drain_cnt_d = DRAIN_LOAD;
            end else if (wd_tc) begin
               state_d     = TIMEOUT;
               check_res_d = encode_result(TOUT, gp_d);
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            // The result uses gp_d so a write landing on this very edge counts.
            if (drain_cnt_q == 32'd0) begin
               state_d     = DONE;
               check_res_d = encode_result(final_st, gp_d);
            end else begin
               drain_cnt_d = drain_cnt_q - 32'd1;
            end
         end
         DONE:    state_d = DONE;
         TIMEOUT: state_d = TIMEOUT;
         default: state_d = RUN;
      endcase
      halt_d = (state_d != RUN);
      done_d = (state_d == DONE) || (state_d == TIMEOUT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RUN;
         drain_cnt_q <= 32'd0;
         gp_q        <= '0;
         check_res_q <= '0;
         halt_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         gp_q        <= gp_d;
         check_res_q <= check_res_d;
         halt_q      <= halt_d;
         done_q      <= done_d;
      end
   end

   assign core_halt    = halt_q;
   assign io_coreDone  = done_q;
   assign io_gpRegVal  = gp_q;
   assign io_check_res = check_res_q;
endmodule

// File: tb/tb_core_status_monitor.sv
// Directed bench for core_status_monitor: vector table plus multi-cycle sequences.
module tb_core_status_monitor;
   localparam logic [31:0] UNIMP = 32'hC000_1073;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_instr;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        core_halt;
   logic        io_coreDone;
   logic [31:0] io_gpRegVal;
   logic [31:0] io_check_res;
   logic [31:0] io_cycles;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        rst_n;
      logic        id_valid;
      logic [31:0] id_instr;
      logic        wb_we;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
      logic        e_halt;
      logic        e_done;
      logic [31:0] e_gp;
      logic [31:0] e_res;
      logic [31:0] e_cyc;
   } vec_t;

   vec_t vecs[$];

   core_status_monitor #(
      .DATA_WIDTH    (32),
      .DRAIN_CYCLES  (3),
      .TIMEOUT_CYCLES(50)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .core_halt   (core_halt),
      .io_coreDone (io_coreDone),
      .io_gpRegVal (io_gpRegVal),
      .io_check_res(io_check_res),
      .io_cycles   (io_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [31:0] ins,
                        input logic we, input logic [4:0] rd, input logic [31:0] d);
      rst_n    = r;
      id_valid = iv;
      id_instr = ins;
      wb_we    = we;
      wb_rd    = rd;
      wb_data  = d;
   endtask

   task automatic idle();
      drive(1'b1, 1'b0, NOP, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, NOP, 1'b0, 5'd0, 32'd0);
      tick();
      idle();
   endtask

   task automatic add(input logic r, input logic iv, input logic [31:0] ins,
                      input logic we, input logic [4:0] rd, input logic [31:0] d,
                      input logic eh, input logic ed, input logic [31:0] eg,
                      input logic [31:0] er, input logic [31:0] ec);
      vec_t v;
      v.rst_n = r;  v.id_valid = iv; v.id_instr = ins;
      v.wb_we = we; v.wb_rd = rd;    v.wb_data = d;
      v.e_halt = eh; v.e_done = ed;  v.e_gp = eg; v.e_res = er; v.e_cyc = ec;
      vecs.push_back(v);
   endtask

   initial begin
      int first_done;
      idle();

      // rst  iv  instr  we  rd  data     halt done gp  res            cycles
      add(0, 0, NOP,   0, 0, 0,          0, 0, 0, 32'h0,          0);
      add(1, 0, NOP,   1, 0, 1,          0, 0, 0, 32'h0,          1);
      add(1, 0, UNIMP, 0, 0, 0,          0, 0, 0, 32'h0,          2);
      add(1, 1, NOP,   0, 0, 0,          0, 0, 0, 32'h0,          3);
      add(1, 0, NOP,   1, 3, 7,          0, 0, 7, 32'h0,          4);
      add(1, 1, UNIMP, 0, 0, 0,          1, 0, 7, 32'h0,          5);
      add(1, 0, NOP,   0, 0, 0,          1, 0, 7, 32'h0,          6);
      add(1, 1, UNIMP, 0, 0, 0,          1, 0, 7, 32'h0,          7);
      add(1, 0, NOP,   0, 0, 0,          1, 1, 7, 32'h8000_0003,  8);
      add(1, 0, NOP,   1, 3, 9,          1, 1, 7, 32'h8000_0003,  8);
      add(0, 0, NOP,   0, 0, 0,          0, 0, 0, 32'h0,          0);
      add(1, 0, NOP,   1, 3, 1,          0, 0, 1, 32'h0,          1);
      add(1, 1, UNIMP, 0, 0, 0,          1, 0, 1, 32'h0,          2);
      add(1, 0, NOP,   0, 0, 0,          1, 0, 1, 32'h0,          3);
      add(1, 0, NOP,   1, 3, 5,          1, 0, 5, 32'h0,          4);
      add(1, 0, NOP,   0, 0, 0,          1, 1, 5, 32'h8000_0002,  5);
      add(1, 0, NOP,   1, 3, 9,          1, 1, 5, 32'h8000_0002,  5);
      add(0, 0, NOP,   0, 0, 0,          0, 0, 0, 32'h0,          0);
      add(1, 1, UNIMP, 0, 0, 0,          1, 0, 0, 32'h0,          1);
      add(1, 0, NOP,   0, 0, 0,          1, 0, 0, 32'h0,          2);
      add(1, 0, NOP,   0, 0, 0,          1, 0, 0, 32'h0,          3);
      add(1, 0, NOP,   1, 3, 1,          1, 1, 1, 32'h4000_0000,  4);

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].id_valid, vecs[i].id_instr,
               vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_data);
         tick();
         chk($sformatf("vec%0d_halt", i), 32'(core_halt), 32'(vecs[i].e_halt));
         chk($sformatf("vec%0d_done", i), 32'(io_coreDone), 32'(vecs[i].e_done));
         chk($sformatf("vec%0d_gp", i), io_gpRegVal, vecs[i].e_gp);
         chk($sformatf("vec%0d_res", i), io_check_res, vecs[i].e_res);
         chk($sformatf("vec%0d_cycles", i), io_cycles, vecs[i].e_cyc);
      end

      // gp=1 written on edge 10, unimp on edge 20: halt from 20, done from 23.
      do_reset();
      for (int i = 1; i <= 25; i++) begin
         drive(1'b1, (i == 20), (i == 20) ? UNIMP : NOP, (i == 10), 5'd3, 32'd1);
         tick();
         chk($sformatf("pass_seq_halt_e%0d", i), 32'(core_halt), 32'(i >= 20));
         chk($sformatf("pass_seq_done_e%0d", i), 32'(io_coreDone), 32'(i >= 23));
      end
      chk("pass_seq_res", io_check_res, 32'h4000_0000);
      chk("pass_seq_gp", io_gpRegVal, 32'd1);

      // Watchdog expiry with no unimp.
      do_reset();
      first_done = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (io_coreDone && first_done == 0) first_done = k;
      end
      chk("timeout_edge", 32'(first_done), 32'd50);
      chk("timeout_cycles", io_cycles, 32'd50);
      chk("timeout_res", io_check_res, 32'hC000_0000);
      chk("timeout_halt", 32'(core_halt), 32'd1);

      // unimp on the same edge the watchdog would fire: drain wins.
      do_reset();
      repeat (49) tick();
      chk("race_pre_cycles", io_cycles, 32'd49);
      drive(1'b1, 1'b1, UNIMP, 1'b0, 5'd0, 32'd0);
      tick();
      idle();
      chk("race_halt", 32'(core_halt), 32'd1);
      chk("race_not_done", 32'(io_coreDone), 32'd0);
      chk("race_cycles", io_cycles, 32'd50);
      repeat (3) tick();
      chk("race_done", 32'(io_coreDone), 32'd1);
      chk("race_res", io_check_res, 32'h8000_0000);
      chk("race_final_cycles", io_cycles, 32'd53);

      // Reset mid-drain clears everything; a later unimp completes normally.
      do_reset();
      drive(1'b1, 1'b0, NOP, 1'b1, 5'd3, 32'd7);
      tick();
      drive(1'b1, 1'b1, UNIMP, 1'b0, 5'd0, 32'd0);
      tick();
      idle();
      tick();
      chk("rst_drain_pre_halt", 32'(core_halt), 32'd1);
      drive(1'b0, 1'b0, NOP, 1'b0, 5'd0, 32'd0);
      tick();
      chk("rst_drain_halt", 32'(core_halt), 32'd0);
      chk("rst_drain_done", 32'(io_coreDone), 32'd0);
      chk("rst_drain_gp", io_gpRegVal, 32'd0);
      chk("rst_drain_res", io_check_res, 32'd0);
      chk("rst_drain_cycles", io_cycles, 32'd0);
      drive(1'b1, 1'b1, UNIMP, 1'b0, 5'd0, 32'd0);
      tick();
      idle();
      chk("rst_redo_halt", 32'(core_halt), 32'd1);
      repeat (2) tick();
      chk("rst_redo_not_done", 32'(io_coreDone), 32'd0);
      tick();
      chk("rst_redo_done", 32'(io_coreDone), 32'd1);
      chk("rst_redo_res", io_check_res, 32'h8000_0000);
      chk("rst_redo_cycles", io_cycles, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
